// File: rtl/ram_portb_arbiter.sv
// Port-B arbiter for a dual-port video RAM: VGA reads win, then the zeroing sequence, then host.
// Host reads return data two cycles after acceptance; the clear walks every address once.
module ram_portb_arbiter #(
    parameter int DATA_WIDTH         = 16,
    parameter int RAM_REGISTER_COUNT = 1024,
    parameter int CLEAR_ON_RESET     = 1,
    localparam int ADDR_W            = $clog2(RAM_REGISTER_COUNT)
) (
    input  logic                  CLK_50,
    input  logic                  resetN,
    input  logic                  vga_active,
    input  logic [ADDR_W-1:0]     vga_addr,
    output logic [DATA_WIDTH-1:0] vga_data,
    input  logic                  clear_start,
    output logic                  clear_busy,
    output logic                  clear_done,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_W-1:0]     host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic                  host_ready,
    output logic                  host_rvalid,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic [ADDR_W-1:0]     ram_address_b,
    output logic [DATA_WIDTH-1:0] ram_data_b,
    output logic                  ram_wren_b,
    input  logic [DATA_WIDTH-1:0] ram_q_b
);

    typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_RD_WAIT} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(RAM_REGISTER_COUNT - 1);
    localparam logic              INIT_CLEAR = (CLEAR_ON_RESET != 0);

    state_t                  state_q, state_d;
    logic [ADDR_W-1:0]       clear_ptr_q, clear_ptr_d;
    logic                    init_q, init_d;
    logic                    pend_q, pend_d;
    logic                    done_q, done_d;
    logic                    rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    clear_req;
    logic                    host_acc;

    // Any outstanding clear request (new, latched during RD_WAIT, or post-reset) blocks the host.
    assign clear_req  = clear_start | pend_q | init_q;
    assign host_ready = resetN & (state_q == ST_IDLE) & ~vga_active & ~clear_req;
    assign host_acc   = host_req & host_ready;

    assign vga_data    = ram_q_b;
    assign clear_busy  = (state_q == ST_CLEAR);
    assign clear_done  = done_q;
    assign host_rvalid = rvalid_q;
    assign host_rdata  = rdata_q;

    always_ff @(posedge CLK_50 or negedge resetN) begin
        if (!resetN) begin
            state_q     <= ST_IDLE;
            clear_ptr_q <= '0;
            init_q      <= INIT_CLEAR;
            pend_q      <= 1'b0;
            done_q      <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            clear_ptr_q <= clear_ptr_d;
            init_q      <= init_d;
            pend_q      <= pend_d;
            done_q      <= done_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        clear_ptr_d = clear_ptr_q;
        init_d      = init_q;
        pend_d      = pend_q;
        done_d      = 1'b0;
        rvalid_d    = 1'b0;
        rdata_d     = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    state_d     = ST_CLEAR;
                    clear_ptr_d = '0;
                    init_d      = 1'b0;
                    pend_d      = 1'b0;
                end else if (host_acc && !host_we) begin
                    state_d = ST_RD_WAIT;
                end
            end
            ST_CLEAR: begin
                // Pointer only advances on cycles where the clear actually owns port B.
                if (!vga_active) begin
                    if (clear_ptr_q == LAST_ADDR) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        clear_ptr_d = clear_ptr_q + 1'b1;
                    end
                end
            end
            ST_RD_WAIT: begin
                state_d  = ST_IDLE;
                rvalid_d = 1'b1;
                rdata_d  = ram_q_b;
                if (clear_start) begin
                    pend_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ram_address_b = vga_addr;
        ram_data_b    = '0;
        ram_wren_b    = 1'b0;
        if (!vga_active) begin
            if (state_q == ST_CLEAR) begin
                ram_address_b = clear_ptr_q;
                ram_wren_b    = 1'b1;
            end else if (host_acc) begin
                ram_address_b = host_addr;
                ram_wren_b    = host_we;
                if (host_we) begin
                    ram_data_b = host_wdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_portb_arbiter.sv
// Bench for ram_portb_arbiter: behavioural RAM on port B, per-cycle reference model,
// an IDLE-state vector table, directed corner sequences and a randomized phase.
module tb_ram_portb_arbiter;
    localparam int DW = 16;
    localparam int N  = 1024;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          vga_active;
    logic [AW-1:0] vga_addr;
    logic [DW-1:0] vga_data;
    logic          clear_start, clear_busy, clear_done;
    logic          host_req, host_we, host_ready, host_rvalid;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata, host_rdata;
    logic [AW-1:0] ram_address_b;
    logic [DW-1:0] ram_data_b;
    logic          ram_wren_b;
    logic [DW-1:0] ram_q;

    always #10 clk = ~clk;

    ram_portb_arbiter #(.DATA_WIDTH(DW), .RAM_REGISTER_COUNT(N), .CLEAR_ON_RESET(1)) dut (
        .CLK_50(clk), .resetN(rst_n),
        .vga_active(vga_active), .vga_addr(vga_addr), .vga_data(vga_data),
        .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ready(host_ready), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .ram_address_b(ram_address_b), .ram_data_b(ram_data_b), .ram_wren_b(ram_wren_b),
        .ram_q_b(ram_q)
    );

    logic [DW-1:0] ram_mem [N];
    always @(posedge clk) begin
        if (ram_wren_b) ram_mem[ram_address_b] <= ram_data_b;
        ram_q <= ram_mem[ram_address_b];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model state: what the arbiter should be doing, in plain terms.
    bit            m_clearing, m_rdwait, m_clear_req, m_done, m_rvalid;
    int            m_ptr;
    logic [DW-1:0] m_rdata, m_saved;
    logic [DW-1:0] ref_mem [N];

    always @(negedge clk) begin
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
        bit            e_wren, e_ready, n_done, n_rvalid;
        logic [62:0]   act_v, exp_v;
        if (!rst_n) begin
            chk("reset_outputs", {clear_busy, clear_done, host_rvalid, host_rdata, ram_wren_b},
                {1'b0, 1'b0, 1'b0, 16'h0, 1'b0});
            m_clearing = 0; m_rdwait = 0; m_clear_req = 1; m_done = 0; m_rvalid = 0;
            m_rdata = '0; m_ptr = 0;
        end else begin
            e_ready = !m_clearing && !m_rdwait && !vga_active && !clear_start && !m_clear_req;
            e_addr = vga_addr; e_data = '0; e_wren = 0;
            if (!vga_active) begin
                if (m_clearing) begin
                    e_addr = AW'(m_ptr); e_wren = 1;
                end else if (e_ready && host_req) begin
                    e_addr = host_addr; e_wren = host_we;
                    if (host_we) e_data = host_wdata;
                end
            end
            exp_v = {m_clearing, m_done, e_ready, m_rvalid, m_rdata, e_addr, e_wren, e_data, ram_q};
            act_v = {clear_busy, clear_done, host_ready, host_rvalid, host_rdata, ram_address_b,
                     ram_wren_b, (ram_wren_b ? ram_data_b : 16'h0), vga_data};
            chk("cycle_model", {1'b0, act_v}, {1'b0, exp_v});
            n_done = 0; n_rvalid = 0;
            if (m_clearing) begin
                if (!vga_active) begin
                    ref_mem[m_ptr] = '0;
                    if (m_ptr == N - 1) begin m_clearing = 0; n_done = 1; end
                    else m_ptr++;
                end
            end else if (m_rdwait) begin
                m_rdwait = 0; n_rvalid = 1; m_rdata = m_saved;
                if (clear_start) m_clear_req = 1;
            end else if (clear_start || m_clear_req) begin
                m_clearing = 1; m_ptr = 0; m_clear_req = 0;
            end else if (e_ready && host_req) begin
                if (host_we) ref_mem[host_addr] = host_wdata;
                else begin m_rdwait = 1; m_saved = ref_mem[host_addr]; end
            end
            m_done = n_done; m_rvalid = n_rvalid;
        end
    end

    typedef struct {
        bit            vga;
        bit            req;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        bit            e_ready;
        bit            e_wren;
        logic [AW-1:0] e_addr;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int nwr, bad_order, done_cnt, busy_cnt, viol, nz;
        bit hit;
        vecs[0] = '{0, 0, 0, 10'h010, 16'h0000, 1, 0, 10'h3A5};
        vecs[1] = '{1, 1, 1, 10'h020, 16'hAAAA, 0, 0, 10'h3A5};
        vecs[2] = '{0, 1, 1, 10'h010, 16'h1234, 1, 1, 10'h010};
        vecs[3] = '{0, 1, 1, 10'h3FF, 16'hBEEF, 1, 1, 10'h3FF};
        vecs[4] = '{0, 1, 0, 10'h010, 16'h0000, 1, 0, 10'h010};
        vecs[5] = '{1, 1, 0, 10'h055, 16'h0000, 0, 0, 10'h3A5};
        vecs[6] = '{0, 1, 1, 10'h000, 16'h5A5A, 1, 1, 10'h000};
        vecs[7] = '{0, 1, 0, 10'h3FF, 16'h0000, 1, 0, 10'h3FF};

        for (int i = 0; i < N; i++) begin ram_mem[i] = 16'hFFFF; ref_mem[i] = 16'hFFFF; end
        rst_n = 0; vga_active = 0; vga_addr = '0; clear_start = 0;
        host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
        repeat (3) tick();

        // Automatic clear after reset release
        rst_n = 1;
        nwr = 0; bad_order = 0; done_cnt = 0;
        for (int k = 0; k < 1100 && done_cnt == 0; k++) begin
            tick(); #4;
            if (ram_wren_b) begin
                if (ram_address_b != AW'(nwr) || ram_data_b != 0) bad_order++;
                nwr++;
            end
            if (clear_done) done_cnt++;
        end
        chk("init_clear_writes", nwr, 1024);
        chk("init_clear_order", bad_order, 0);
        chk("init_clear_done", done_cnt, 1);
        tick(); #4;
        chk("done_one_cycle", clear_done, 0);
        nz = 0;
        for (int i = 0; i < N; i++) if (ram_mem[i] !== 16'h0000) nz++;
        chk("ram_all_zero", nz, 0);

        // IDLE arbitration vectors
        vga_addr = 10'h3A5;
        foreach (vecs[i]) begin
            tick();
            vga_active = vecs[i].vga; host_req = vecs[i].req; host_we = vecs[i].we;
            host_addr = vecs[i].addr; host_wdata = vecs[i].wdata;
            #4;
            chk("vec_ready", host_ready, vecs[i].e_ready);
            chk("vec_wren_addr", {ram_wren_b, ram_address_b}, {vecs[i].e_wren, vecs[i].e_addr});
            if (vecs[i].e_wren) chk("vec_wdata", ram_data_b, vecs[i].wdata);
            tick(); host_req = 0; vga_active = 0;
            tick();
        end

        // Write then read 0x1234 @0x010, with a back-to-back request held through RD_WAIT
        tick(); host_req = 1; host_we = 1; host_addr = 10'h010; host_wdata = 16'h1234; #4;
        chk("wr_ready", host_ready, 1);
        tick(); host_we = 0; #4;
        chk("rd_ready", host_ready, 1);
        tick(); #4;
        chk("rdwait_ready", host_ready, 0);
        chk("rdwait_rvalid", host_rvalid, 0);
        tick(); #4;
        chk("rd_rvalid", host_rvalid, 1);
        chk("rd_rdata", host_rdata, 16'h1234);
        chk("b2b_ready", host_ready, 1);
        tick(); host_req = 0;
        repeat (3) tick();

        // Host held off by VGA, accepted right after it falls
        vga_active = 1; host_req = 1; host_we = 1; host_addr = 10'h050; host_wdata = 16'hCAFE;
        for (int k = 0; k < 3; k++) begin
            #4; chk("vga_blocks_host", {host_ready, ram_wren_b}, 2'b00);
            tick();
        end
        vga_active = 0; #4;
        chk("after_vga_accept", {host_ready, ram_wren_b, ram_address_b}, {1'b1, 1'b1, 10'h050});
        tick(); host_req = 0;
        tick();

        // Same-cycle clear_start vs host write; clear_start during CLEAR ignored
        clear_start = 1; host_req = 1; host_we = 1; host_addr = 10'h020; host_wdata = 16'h7777; #4;
        chk("tie_ready", {host_ready, ram_wren_b}, 2'b00);
        busy_cnt = 0; done_cnt = 0;
        for (int k = 0; k < 1100 && done_cnt == 0; k++) begin
            tick(); clear_start = (k == 10); #4;
            if (clear_busy) busy_cnt++;
            if (clear_busy && host_ready) viol++;
            if (clear_done) done_cnt++;
        end
        chk("tie_busy_cycles", busy_cnt, 1024);
        chk("tie_host_after_done", {clear_done, host_ready, ram_wren_b, ram_address_b, ram_data_b},
            {1'b1, 1'b1, 1'b1, 10'h020, 16'h7777});
        tick(); host_req = 0; clear_start = 0;
        tick();

        // Clear with VGA owning every other cycle
        clear_start = 1;
        tick(); clear_start = 0;
        busy_cnt = 0; viol = 0; done_cnt = 0;
        for (int k = 0; k < 2200 && done_cnt == 0; k++) begin
            if (k > 0) tick();
            vga_active = (k % 2 == 0); vga_addr = AW'($urandom);
            #4;
            if (clear_busy) busy_cnt++;
            if (vga_active && ram_wren_b) viol++;
            if (clear_done) done_cnt++;
        end
        chk("vga_clear_cycles", busy_cnt, 2048);
        chk("vga_clear_no_wr", viol, 0);
        chk("vga_clear_done", done_cnt, 1);
        tick(); vga_active = 0;
        tick();

        // Reset in the middle of a clear
        clear_start = 1;
        tick(); clear_start = 0;
        hit = 0;
        for (int k = 0; k < 1100 && !hit; k++) begin
            tick(); #4;
            if (ram_wren_b && ram_address_b == 10'h200) hit = 1;
        end
        chk("reached_0x200", hit, 1);
        rst_n = 0; #1;
        chk("async_reset_outs", {clear_busy, clear_done, host_rvalid, host_rdata, ram_wren_b},
            {1'b0, 1'b0, 1'b0, 16'h0, 1'b0});
        tick(); tick();
        rst_n = 1;
        tick(); #4;
        chk("restart_at_zero", {clear_busy, ram_wren_b, ram_address_b}, {1'b1, 1'b1, 10'h000});
        done_cnt = 0;
        for (int k = 0; k < 1100 && done_cnt == 0; k++) begin
            tick(); #4;
            if (clear_done) done_cnt++;
        end
        chk("restart_done", done_cnt, 1);

        // Randomized traffic against the reference model
        for (int k = 0; k < 4000; k++) begin
            tick();
            vga_active  = ($urandom % 3 == 0);
            vga_addr    = AW'($urandom);
            host_req    = ($urandom % 2 == 0);
            host_we     = ($urandom % 2 == 0);
            host_addr   = AW'($urandom % 16);
            host_wdata  = DW'($urandom);
            clear_start = ($urandom % 900 == 0);
        end
        tick();
        vga_active = 0; host_req = 0; clear_start = 0;
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
